// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch stage: redirect select codes, the NOP
// word loaded on bubbles, and the fetch FSM state encoding.
package pipe_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_REQ  = 2'b00,
        FS_WAIT = 2'b01,
        FS_HOLD = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/pipeif_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface pipeif_fetch_if;

    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ready;
    logic        im_rvalid;
    logic [31:0] im_rdata;

    modport master (
        output im_req, im_addr,
        input  im_ready, im_rvalid, im_rdata
    );

    modport slave (
        input  im_req, im_addr,
        output im_ready, im_rvalid, im_rdata
    );

endinterface

// File: rtl/pipeif_npc.sv
// Redirect target select from decode. Targets are word aligned by forcing
// the low two bits to zero; the sequential code yields zero because the
// fetch stage computes pc+4 itself.
module pipeif_npc
    import pipe_pkg::*;
(
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] ra,
    input  logic [31:0] jpc,
    output logic [31:0] tgt
);

    // Pick the target for the requested redirect kind and align it.
    always_comb begin
        tgt = 32'h0;
        case (pcsource)
            PCSRC_BR: tgt = {bpc[31:2], 2'b00};
            PCSRC_JR: tgt = {ra[31:2],  2'b00};
            PCSRC_J:  tgt = {jpc[31:2], 2'b00};
            default:  tgt = 32'h0;
        endcase
    end

endmodule

// File: rtl/pipeif_fetch.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency
// instruction memory and produces the IF/ID register for decode.
// Redirects from decode take effect after one delay slot.
// Optional macro PIPEIF_PERF_EN adds a free-running bubble counter port.
module pipeif_fetch
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [1:0]        pcsource,
    input  logic [31:0]       bpc,
    input  logic [31:0]       ra,
    input  logic [31:0]       jpc,
    input  logic              nostall,
    pipeif_fetch_if.master    im,
    output logic [31:0]       dpc4,
    output logic [31:0]       inst,
`ifdef PIPEIF_PERF_EN
    output logic [31:0]       bubble_cnt,
`endif
    output logic              dvalid
);

    fetch_state_t state;
    logic         req_q;
    logic [31:0]  pc;
    logic [31:0]  pc4;
    logic [31:0]  hold_buf;
    logic [31:0]  redir_tgt;
    logic         redir_v;
    logic [31:0]  tgt;
    logic [31:0]  dlv_inst;
    logic         deliver;
    logic         take;

    pipeif_npc u_npc (
        .pcsource (pcsource),
        .bpc      (bpc),
        .ra       (ra),
        .jpc      (jpc),
        .tgt      (tgt)
    );

    assign pc4        = pc + 32'd4;
    assign im.im_req  = req_q;
    assign im.im_addr = pc;

    // A fetched word reaches IF/ID either straight from memory or from the
    // hold buffer, but only when decode can advance.
    assign deliver  = nostall & (((state == FS_WAIT) & im.im_rvalid) | (state == FS_HOLD));
    assign dlv_inst = (state == FS_HOLD) ? hold_buf : im.im_rdata;
    // Decode only redirects for a real, non-stalled instruction.
    assign take     = dvalid & nostall & (pcsource != PCSRC_SEQ);

    // Fetch FSM with registered request strobe; buffers a word decode could not take.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state    <= FS_REQ;
            req_q    <= 1'b1;
            hold_buf <= 32'h0;
        end else begin
            case (state)
                FS_REQ: begin
                    if (im.im_ready) begin
                        state <= FS_WAIT;
                        req_q <= 1'b0;
                    end
                end
                FS_WAIT: begin
                    if (im.im_rvalid) begin
                        if (nostall) begin
                            state <= FS_REQ;
                            req_q <= 1'b1;
                        end else begin
                            state    <= FS_HOLD;
                            hold_buf <= im.im_rdata;
                        end
                    end
                end
                FS_HOLD: begin
                    if (nostall) begin
                        state <= FS_REQ;
                        req_q <= 1'b1;
                    end
                end
                default: begin
                    state <= FS_REQ;
                    req_q <= 1'b1;
                end
            endcase
        end
    end

    // PC advance and pending-redirect bookkeeping; the outstanding fetch is the delay slot.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            pc        <= RESET_PC;
            redir_v   <= 1'b0;
            redir_tgt <= 32'h0;
        end else if (deliver) begin
            // Delay slot lands in the same cycle as the redirect: use the live target.
            if (take)
                pc <= tgt;
            else if (redir_v)
                pc <= redir_tgt;
            else
                pc <= pc4;
            redir_v <= 1'b0;
        end else if (take) begin
            redir_tgt <= tgt;
            redir_v   <= 1'b1;
        end
    end

    // IF/ID register: hold on stall, load a word on delivery, otherwise a bubble.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            dpc4   <= 32'h0;
            inst   <= NOP_INST;
            dvalid <= 1'b0;
        end else if (nostall) begin
            if (deliver) begin
                dpc4   <= pc4;
                inst   <= dlv_inst;
                dvalid <= 1'b1;
            end else begin
                inst   <= NOP_INST;
                dvalid <= 1'b0;
            end
        end
    end

`ifdef PIPEIF_PERF_EN
    // Count cycles where decode advanced but received a bubble.
    always_ff @(posedge clk) begin
        if (!clrn)
            bubble_cnt <= 32'h0;
        else if (nostall && !deliver)
            bubble_cnt <= bubble_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_pipeif_fetch.sv
// Directed bench for pipeif_fetch: sequential fetch, slow memory, decode
// stall with hold buffer, branch/jump/jr redirects with delay slot,
// pc wrap and mid-operation reset.
module tb_pipeif_fetch;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        clrn;
    logic [1:0]  pcsource;
    logic [31:0] bpc, ra, jpc;
    logic        nostall;
    logic [31:0] dpc4, inst;
    logic        dvalid;
`ifdef PIPEIF_PERF_EN
    logic [31:0] bubble_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    pipeif_fetch_if im ();

    pipeif_fetch #(.RESET_PC(32'h0)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .ra         (ra),
        .jpc        (jpc),
        .nostall    (nostall),
        .im         (im.master),
        .dpc4       (dpc4),
        .inst       (inst),
`ifdef PIPEIF_PERF_EN
        .bubble_cnt (bubble_cnt),
`endif
        .dvalid     (dvalid)
    );

    always #5 clk = ~clk;

    // Decode must never issue a second redirect before the delay slot lands.
    always @(posedge clk) begin
        if (clrn && dut.redir_v && dvalid && nostall && pcsource != PCSRC_SEQ) begin
            n_err++;
            $error("FAIL double_redirect: got pcsource %0d with redirect pending, expected 0", pcsource);
        end
    end

    function automatic logic [31:0] w(input logic [31:0] a);
        return 32'hA000_0000 ^ a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic dv, input logic [31:0] ins,
                            input logic [31:0] d4);
        chk({tag, ".dvalid"}, {31'h0, dvalid}, {31'h0, dv});
        chk({tag, ".inst"}, inst, ins);
        chk({tag, ".dpc4"}, dpc4, d4);
    endtask

    // Zero-wait fetch of one word: accept cycle, then data cycle.
    task automatic xfer(input logic [31:0] addr);
        im.im_ready  = 1'b1;
        im.im_rvalid = 1'b0;
        tick();
        im.im_ready  = 1'b0;
        im.im_rvalid = 1'b1;
        im.im_rdata  = w(addr);
        tick();
        im.im_rvalid = 1'b0;
    endtask

    initial begin
        clrn = 1'b0; nostall = 1'b1; pcsource = PCSRC_SEQ;
        bpc = 32'h0; ra = 32'h0; jpc = 32'h0;
        im.im_ready = 1'b0; im.im_rvalid = 1'b0; im.im_rdata = 32'h0;
        tick(); tick();

        // Reset state
        chk_ifid("reset", 1'b0, 32'h0, 32'h0);
        chk("reset.im_req", {31'h0, im.im_req}, 32'h1);
        chk("reset.im_addr", im.im_addr, 32'h0);
`ifdef PIPEIF_PERF_EN
        chk("reset.bubble_cnt", bubble_cnt, 32'h0);
`endif

        // Sequential fetch 0,4,8 with 1-cycle memory
        clrn = 1'b1;
        im.im_ready = 1'b1;
        tick();
        chk("seq0.im_req_wait", {31'h0, im.im_req}, 32'h0);
        chk_ifid("seq0.bubble", 1'b0, 32'h0, 32'h0);
        im.im_ready = 1'b0; im.im_rvalid = 1'b1; im.im_rdata = w(32'h0);
        tick();
        im.im_rvalid = 1'b0;
        chk_ifid("seq0.real", 1'b1, w(32'h0), 32'h4);
        chk("seq0.next_addr", im.im_addr, 32'h4);
        im.im_ready = 1'b1;
        tick();
        chk_ifid("seq4.bubble", 1'b0, 32'h0, 32'h4);
        im.im_ready = 1'b0; im.im_rvalid = 1'b1; im.im_rdata = w(32'h4);
        tick();
        im.im_rvalid = 1'b0;
        chk_ifid("seq4.real", 1'b1, w(32'h4), 32'h8);
        chk("seq4.next_addr", im.im_addr, 32'h8);
        xfer(32'h8);
        chk_ifid("seq8.real", 1'b1, w(32'h8), 32'hC);
        xfer(32'hC);
        chk("seq.addr10", im.im_addr, 32'h10);

        // Slow memory: rvalid three cycles after acceptance
        im.im_ready = 1'b1;
        tick();
        im.im_ready = 1'b0;
        chk_ifid("slow.b1", 1'b0, 32'h0, 32'h10);
        tick();
        chk_ifid("slow.b2", 1'b0, 32'h0, 32'h10);
        chk("slow.im_req", {31'h0, im.im_req}, 32'h0);
        tick();
        chk_ifid("slow.b3", 1'b0, 32'h0, 32'h10);
        im.im_rvalid = 1'b1; im.im_rdata = w(32'h10);
        tick();
        im.im_rvalid = 1'b0;
        chk_ifid("slow.real", 1'b1, w(32'h10), 32'h14);

        // Decode stall while the word for 0x20 arrives
        xfer(32'h14); xfer(32'h18); xfer(32'h1C);
        chk_ifid("stall.pre", 1'b1, w(32'h1C), 32'h20);
        nostall = 1'b0;
        im.im_ready = 1'b1;
        tick();
        im.im_ready = 1'b0; im.im_rvalid = 1'b1; im.im_rdata = w(32'h20);
        tick();
        chk_ifid("stall.c2", 1'b1, w(32'h1C), 32'h20);
        // Garbage with rvalid while in HOLD must be ignored
        im.im_rdata = 32'hDEAD_BEEF;
        tick();
        chk("stall.im_req_hold", {31'h0, im.im_req}, 32'h0);
        tick();
        chk_ifid("stall.c4", 1'b1, w(32'h1C), 32'h20);
        nostall = 1'b1;
        tick();
        im.im_rvalid = 1'b0;
        chk_ifid("stall.release", 1'b1, w(32'h20), 32'h24);
        chk("stall.next_addr", im.im_addr, 32'h24);
        chk("stall.im_req", {31'h0, im.im_req}, 32'h1);

        // Branch at 0x40 to 0x100, delay slot 0x44 fetched after redirect
        for (int a = 32'h24; a < 32'h44; a += 4) xfer(a);
        chk_ifid("br.inst", 1'b1, w(32'h40), 32'h44);
        pcsource = PCSRC_BR; bpc = 32'h100;
        im.im_ready = 1'b1;
        tick();
        pcsource = PCSRC_SEQ;
        im.im_ready = 1'b0; im.im_rvalid = 1'b1; im.im_rdata = w(32'h44);
        tick();
        im.im_rvalid = 1'b0;
        chk_ifid("br.slot", 1'b1, w(32'h44), 32'h48);
        chk("br.target", im.im_addr, 32'h100);

        // Jump at 0x100 to 0x80 via jpc
        xfer(32'h100);
        pcsource = PCSRC_J; jpc = 32'h80;
        im.im_ready = 1'b1;
        tick();
        pcsource = PCSRC_SEQ;
        im.im_ready = 1'b0; im.im_rvalid = 1'b1; im.im_rdata = w(32'h104);
        tick();
        im.im_rvalid = 1'b0;
        chk_ifid("j.slot", 1'b1, w(32'h104), 32'h108);
        chk("j.target", im.im_addr, 32'h80);

        // jr at 0x80, ra=0x203, delay slot arrives in the same cycle as the redirect
        xfer(32'h80);
        nostall = 1'b0; pcsource = PCSRC_JR; ra = 32'h203;
        im.im_ready = 1'b1;
        tick();
        chk_ifid("jr.stalled", 1'b1, w(32'h80), 32'h84);
        nostall = 1'b1;
        im.im_ready = 1'b0; im.im_rvalid = 1'b1; im.im_rdata = w(32'h84);
        tick();
        pcsource = PCSRC_SEQ;
        im.im_rvalid = 1'b0;
        chk_ifid("jr.slot", 1'b1, w(32'h84), 32'h88);
        chk("jr.target", im.im_addr, 32'h200);

        // Reset while in WAIT, stale rvalid afterwards
        im.im_ready = 1'b1;
        tick();
        im.im_ready = 1'b0;
        clrn = 1'b0;
        tick();
        chk_ifid("rst.ifid", 1'b0, 32'h0, 32'h0);
        chk("rst.im_addr", im.im_addr, 32'h0);
        chk("rst.im_req", {31'h0, im.im_req}, 32'h1);
`ifdef PIPEIF_PERF_EN
        chk("rst.bubble_cnt", bubble_cnt, 32'h0);
`endif
        clrn = 1'b1;
        im.im_rvalid = 1'b1; im.im_rdata = 32'hBAD0_BAD0;
        tick();
        chk_ifid("rst.stale1", 1'b0, 32'h0, 32'h0);
        tick();
        im.im_rvalid = 1'b0;
        chk_ifid("rst.stale2", 1'b0, 32'h0, 32'h0);
        chk("rst.addr_after", im.im_addr, 32'h0);
`ifdef PIPEIF_PERF_EN
        chk("rst.bubble_cnt2", bubble_cnt, 32'h2);
`endif
        xfer(32'h0);
        chk_ifid("rst.refetch", 1'b1, w(32'h0), 32'h4);

        // PC wrap: jump to 0xFFFFFFFC, its pc+4 wraps to 0
        pcsource = PCSRC_J; jpc = 32'hFFFF_FFFC;
        im.im_ready = 1'b1;
        tick();
        pcsource = PCSRC_SEQ;
        im.im_ready = 1'b0; im.im_rvalid = 1'b1; im.im_rdata = w(32'h4);
        tick();
        im.im_rvalid = 1'b0;
        chk("wrap.target", im.im_addr, 32'hFFFF_FFFC);
        xfer(32'hFFFF_FFFC);
        chk_ifid("wrap.ifid", 1'b1, w(32'hFFFF_FFFC), 32'h0);
        chk("wrap.next_addr", im.im_addr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeif_fetch.md
Name: pipeif_fetch

Overview:
- Instruction-fetch stage of the 5-stage pipelined CPU, and the producer of the IF/ID register consumed by the decode stage.
- Owns the PC and issues requests to a variable-latency instruction memory.
- Delivers dpc4/inst/dvalid to decode, and applies decode's redirect (pcsource/bpc/ra/jpc) with one architectural delay slot.
- Honours decode's nostall back-pressure.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- clrn  input  1  reset; synchronous, active-low.
- pcsource  input  2  redirect select from decode: 00 pc+4, 01 bpc, 10 ra (jr), 11 jpc.
- bpc  input  32  branch target from decode.
- ra  input  32  forwarded register-a value (jr target).
- jpc  input  32  jump target from decode.
- nostall  input  1  decode may accept/advance (1) or must hold (0).
- im_req  output  1  instruction memory request valid.
- im_addr  output  32  request address, equal to pc.
- im_ready  input  1  memory accepts request this cycle (im_req & im_ready).
- im_rvalid  input  1  read data valid.
- im_rdata  input  32  instruction word.
- dpc4  output  32  IF/ID: fetched pc+4.
- inst  output  32  IF/ID: instruction; 32'h0 (NOP) when bubble.
- dvalid  output  1  IF/ID holds a real fetched instruction.

Behaviour:
- Reset (clrn=0 at edge): pc=RESET_PC; state=REQ; dpc4=0; inst=0; dvalid=0; redir_v=0; hold buffer empty.
- FSM states:
  - REQ: im_req=1, im_addr=pc. On im_ready go to WAIT; otherwise stay.
  - WAIT: im_req=0. On im_rvalid, if nostall, load IF/ID {pc+4, im_rdata, dvalid=1}, advance pc, go to REQ. If nostall=0, capture im_rdata into hold buffer and go to HOLD.
  - HOLD: im_req=0. When nostall=1, load IF/ID from hold buffer, advance pc, go to REQ.
- im_rvalid is ignored outside WAIT.
- Minimum latency: 2 cycles per instruction with a 0-wait memory (REQ→WAIT→REQ).
- IF/ID update rule:
  - nostall=0: hold all three fields.
  - nostall=1 and no delivery this cycle: inst=0, dvalid=0, dpc4 held.
  - A delivered instruction therefore sits in decode for exactly one non-stalled cycle.
- Redirect capture: when dvalid & nostall & pcsource!=00, the selected target (low 2 bits forced to 00) is taken.
  - The fetch outstanding at that time is the delay slot, and completes normally.
  - If the delay-slot delivery happens in the same cycle, pc ← live target.
  - Otherwise the target goes to redir_tgt with redir_v=1.
- PC advance (at delivery): pc ← redir_v ? redir_tgt : pc+4, then redir_v clears. pc+4 wraps modulo 2^32.
- Redirect while ID is stalled (nostall=0) is not captured; decode re-presents it.
- A second redirect while redir_v=1 cannot occur, because the delay slot is not yet delivered; the bench asserts this.
- Reset mid-operation discards any outstanding request, hold buffer contents and pending redirect. The memory must not deliver stale data after reset.

Optional Feature:
- Macro PIPEIF_PERF_EN.
- Defined: adds output port bubble_cnt (32-bit).
  - Resets to 0.
  - Increments on every cycle where nostall=1 and IF/ID loads a bubble.
  - Wraps at 2^32.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package pipe_pkg:
  - PCSRC_SEQ/BR/JR/J constants (2'b00..2'b11).
  - NOP_INST = 32'h0.
  - Fetch FSM state encoding (REQ, WAIT, HOLD).
- One natural sub-module: pipeif_npc, a combinational target select from pcsource/bpc/ra/jpc with low-bit masking. Fetch FSM, PC and IF/ID stay in pipeif_fetch.

Test Plan:
- Reset, then release clrn with RESET_PC=0, im_ready=1 and 1-cycle rvalid: im_addr sequence 0,4,8. IF/ID alternates bubble/real, and dpc4=4,8,12 on real cycles.
- im_rvalid delayed 3 cycles for address 0x10: im_req low during WAIT, inst=0/dvalid=0 for 3 decode cycles, then inst=rdata, dpc4=0x14.
- nostall=0 for 4 cycles while rvalid arrives for 0x20: IF/ID held and data buffered in HOLD. On nostall=1, inst=buffered word and dpc4=0x24. Next im_addr=0x24.
- Branch at 0x40 delivered, decode asserts pcsource=01 with bpc=0x100 while fetch of 0x44 is pending: 0x44 is delivered (delay slot), next im_addr=0x100.
- jr at 0x80, pcsource=10, ra=0x203 with delay-slot rvalid in the same cycle: pc becomes 0x200, im_addr=0x200.
- clrn=0 while in WAIT, with a late rvalid afterwards: outputs at reset values, im_addr=RESET_PC, stale data never appears on inst. With PIPEIF_PERF_EN defined, bubble_cnt=0 after reset.
